// File: rtl/lab2_proc_multi_drop_unit.sv
// Drop unit that discards up to p_max_pending late memory responses, tracking
// owed drops in a saturating counter and exporting drop statistics.
module lab2_proc_multi_drop_unit #(
  parameter int p_msg_nbits   = 1,
  parameter int p_max_pending = 4,
  parameter int p_stat_nbits  = 16,
  localparam int p_cnt_nbits  = $clog2(p_max_pending + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    drop,
  input  logic [p_msg_nbits-1:0]  istream_msg,
  input  logic                    istream_val,
  output logic                    istream_rdy,
  output logic [p_msg_nbits-1:0]  ostream_msg,
  output logic                    ostream_val,
  input  logic                    ostream_rdy,
  output logic [p_cnt_nbits-1:0]  pending,
  output logic                    overflow,
  output logic [p_stat_nbits-1:0] ndropped
);

  localparam logic [p_cnt_nbits-1:0] PendMax = p_cnt_nbits'(p_max_pending);

  logic [p_cnt_nbits-1:0]  pending_q, pending_d;
  logic                    overflow_q, overflow_d;
  logic [p_stat_nbits-1:0] ndropped_q, ndropped_d;

  logic dropping;
  logic go;
  logic drop_go;

  // Handshake: a transfer happens on a cycle where val && rdy on a stream.
  // While dropping, the input is always ready and the output never valid,
  // so an owed drop completes without waiting on the downstream.
  assign dropping    = (pending_q != '0) || drop;
  assign go          = istream_val && istream_rdy;
  assign drop_go     = go && dropping;

  assign ostream_msg = istream_msg;
  assign ostream_val = istream_val && !dropping;
  assign istream_rdy = dropping ? 1'b1 : ostream_rdy;

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    ndropped_d = ndropped_q;
    // inc && dec together (drop with a consumed packet) nets to no change.
    if (drop && !drop_go) begin
      if (pending_q == PendMax) overflow_d = 1'b1;
      else                      pending_d  = pending_q + p_cnt_nbits'(1);
    end else if (!drop && drop_go) begin
      pending_d = pending_q - p_cnt_nbits'(1);
    end
    if (drop_go) ndropped_d = ndropped_q + p_stat_nbits'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      ndropped_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ndropped_q <= ndropped_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign ndropped = ndropped_q;

endmodule

// File: tb/tb_lab2_proc_multi_drop_unit.sv
// Self-checking bench for lab2_proc_multi_drop_unit: scoreboarded pass-through
// messages plus directed drop, saturation, reset and statistic-wrap scenarios.
module tb_lab2_proc_multi_drop_unit;

  localparam int MW = 8;
  localparam int MAXP = 4;
  localparam int SW = 4;
  localparam int CW = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          drop;
  logic [MW-1:0] istream_msg;
  logic          istream_val;
  logic          istream_rdy;
  logic [MW-1:0] ostream_msg;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [CW-1:0] pending;
  logic          overflow;
  logic [SW-1:0] ndropped;

  lab2_proc_multi_drop_unit #(
    .p_msg_nbits(MW), .p_max_pending(MAXP), .p_stat_nbits(SW)
  ) dut (
    .clk(clk), .reset(reset), .drop(drop),
    .istream_msg(istream_msg), .istream_val(istream_val), .istream_rdy(istream_rdy),
    .ostream_msg(ostream_msg), .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .pending(pending), .overflow(overflow), .ndropped(ndropped)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [MW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_nd = 0;
  bit hs;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor output handshake at negedge, then advance past posedge.
  task automatic tick();
    @(negedge clk);
    hs = istream_val && istream_rdy;
    if (ostream_val && ostream_rdy) begin
      if (exp_q.size() == 0) check_eq("unexpected_out", {24'd0, ostream_msg}, 32'hdead);
      else check_eq("out_msg", {24'd0, ostream_msg}, {24'd0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int p, input int ov, input int nd);
    check_eq({tag, "_pending"}, 32'(pending), 32'(p));
    check_eq({tag, "_overflow"}, 32'(overflow), 32'(ov));
    check_eq({tag, "_ndropped"}, 32'(ndropped), 32'(nd % 16));
  endtask

  // driver: packet expected to pass through to ostream
  task automatic send_pass(input logic [MW-1:0] m, input bit rand_rdy);
    exp_q.push_back(m);
    drop = 1'b0;
    istream_val = 1'b1;
    istream_msg = m;
    hs = 1'b0;
    for (int i = 0; i < 40 && !hs; i++) begin
      ostream_rdy = (rand_rdy && i < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    check_eq("pass_handshake", 32'(hs), 32'd1);
    istream_val = 1'b0;
  endtask

  // driver: packet expected to be dropped in this cycle, downstream stalled
  task automatic send_drop(input logic [MW-1:0] m, input logic d);
    drop = d;
    istream_val = 1'b1;
    istream_msg = m;
    ostream_rdy = 1'b0;
    #2;
    check_eq("drop_irdy", 32'(istream_rdy), 32'd1);
    check_eq("drop_oval", 32'(ostream_val), 32'd0);
    check_eq("drop_omsg", {24'd0, ostream_msg}, {24'd0, m});
    tick();
    check_eq("drop_handshake", 32'(hs), 32'd1);
    exp_nd++;
    istream_val = 1'b0;
    drop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; drop = 1'b0; istream_val = 1'b0; istream_msg = '0; ostream_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_state("reset", 0, 0, 0);

    // pass-through
    send_pass(8'h11, 1'b1);
    send_pass(8'h22, 1'b1);
    send_pass(8'h33, 1'b1);
    for (int i = 0; i < 8; i++) send_pass(8'($urandom_range(0, 255)), 1'b1);
    check_state("passthru", 0, 0, 0);
    check_eq("passthru_drained", 32'(exp_q.size()), 32'd0);

    // same-cycle drop with downstream stalled
    send_drop(8'hAA, 1'b1);
    check_state("samecyc", 0, 0, exp_nd);
    send_pass(8'hBB, 1'b0);
    check_state("after_bb", 0, 0, exp_nd);

    // multiple owed drops
    drop = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("owed_pending", 32'(pending), 32'(k));
    end
    drop = 1'b0;
    send_drop(8'h01, 1'b0); check_state("owed1", 2, 0, exp_nd);
    send_drop(8'h02, 1'b0); check_state("owed2", 1, 0, exp_nd);
    send_drop(8'h03, 1'b0); check_state("owed3", 0, 0, exp_nd);
    send_pass(8'h04, 1'b1);
    check_state("owed4", 0, 0, 4);

    // simultaneous drop and arrival with two owed
    drop = 1'b1;
    tick(); tick();
    drop = 1'b0;
    check_eq("simul_pre", 32'(pending), 32'd2);
    send_drop(8'h5A, 1'b1);
    check_state("simul", 2, 0, exp_nd);
    send_drop(8'h5B, 1'b0);
    send_drop(8'h5C, 1'b0);
    check_state("simul_drain", 0, 0, exp_nd);

    // saturation then reset
    drop = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("sat_pending", 32'(pending), 32'((k < MAXP) ? k : MAXP));
      check_eq("sat_overflow", 32'(overflow), 32'((k >= 5) ? 1 : 0));
    end
    drop = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_nd = 0;
    check_state("sat_reset", 0, 0, 0);
    send_pass(8'hC3, 1'b0);
    check_state("post_reset", 0, 0, 0);

    // statistic wrap
    for (int k = 1; k <= 17; k++) begin
      send_drop(8'($urandom_range(0, 255)), 1'b1);
      if (k >= 15) check_eq("wrap_ndropped", 32'(ndropped), 32'(k % 16));
    end
    check_state("wrap", 0, 0, 1);
    send_pass(8'h7E, 1'b1);

    check_eq("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
